// File: rtl/sd_sector_loader.sv
// sd_sector_loader
//   Loads N consecutive 512-byte sectors from an SPI SD-card interface into
//   on-chip memory. One single-block read is issued per sector. Every received
//   byte is written one cycle after its strobe. The block reports completion
//   (done pulse) or a sticky timeout error.
//
// Ports
//   clock, reset                   system clock, async active-high reset
//   start, start_sector,
//   sector_count, dest_base        load request (sampled in IDLE/DONE/ERROR)
//   busy, done, error              status to the boot/load controller
//   sd_idle, sd_byte_valid, sd_byte  from the SD interface
//   sd_begin_read, sd_addr         single-block read request to the SD interface
//   mem_we, mem_addr, mem_wdata    byte write port into PRG/CHR RAM
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start
// WAIT_RDY | waiting for the SD interface to report idle
// ISSUE    | sd_begin_read pulse with the card address of the current sector
// WAIT_ACK | waiting for sd_idle to drop; re-issues after two idle cycles
// RECEIVE  | writing data bytes; the 512th byte ends the sector
// SECT_END | advance the sector count; finish or fetch the next sector
// DONE     | one-cycle done pulse
// ERROR    | timeout seen; error held until the next accepted start

module sd_sector_loader #(
    parameter int MEM_ADDR_W     = 16,
    parameter int SECTOR_SHIFT   = 0,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           start_sector,
    input  logic [15:0]           sector_count,
    input  logic [MEM_ADDR_W-1:0] dest_base,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  sd_idle,
    input  logic                  sd_byte_valid,
    input  logic [7:0]            sd_byte,
    output logic                  sd_begin_read,
    output logic [31:0]           sd_addr,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_wdata
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_ISSUE,
        S_WAIT_ACK,
        S_RECEIVE,
        S_SECT_END,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state;
    logic [31:0]           base_sector;
    logic [15:0]           num_sectors;
    logic [MEM_ADDR_W-1:0] base_addr;
    logic [8:0]            byte_cnt;
    logic [15:0]           sect_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic                  ack_wait;

    logic [31:0]           next_sd_addr;
    logic [MEM_ADDR_W-1:0] next_mem_addr;
    logic                  tmo_counting;
    logic                  tmo_expire;

    always_comb begin
        next_sd_addr  = (base_sector + {16'd0, sect_cnt}) << SECTOR_SHIFT;
        // sector offset is truncated to the memory width, so the sum wraps
        next_mem_addr = base_addr + MEM_ADDR_W'({sect_cnt, 9'd0}) + MEM_ADDR_W'(byte_cnt);
        tmo_counting  = (state == S_WAIT_RDY) || (state == S_ISSUE) ||
                        (state == S_WAIT_ACK) || (state == S_RECEIVE);
        // a byte arriving in the expiry cycle takes priority over the timeout
        tmo_expire    = tmo_counting && (tmo_cnt == T_LAST) && !sd_byte_valid;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            sd_begin_read <= 1'b0;
            sd_addr       <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            base_sector   <= '0;
            num_sectors   <= '0;
            base_addr     <= '0;
            byte_cnt      <= '0;
            sect_cnt      <= '0;
            tmo_cnt       <= '0;
            ack_wait      <= 1'b0;
        end else begin
            done          <= 1'b0;
            mem_we        <= 1'b0;
            sd_begin_read <= 1'b0;

            if (tmo_expire) begin
                state <= S_ERROR;
                error <= 1'b1;
                busy  <= 1'b0;
            end else begin
                if (tmo_counting)
                    tmo_cnt <= sd_byte_valid ? '0 : tmo_cnt + 1'b1;

                case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (state == S_DONE)
                            state <= S_IDLE;
                        if (start) begin
                            base_sector <= start_sector;
                            num_sectors <= sector_count;
                            base_addr   <= dest_base;
                            error       <= 1'b0;
                            byte_cnt    <= '0;
                            sect_cnt    <= '0;
                            tmo_cnt     <= '0;
                            ack_wait    <= 1'b0;
                            if (sector_count == 16'd0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_WAIT_RDY;
                                busy  <= 1'b1;
                            end
                        end
                    end

                    S_WAIT_RDY: begin
                        if (sd_idle) begin
                            state         <= S_ISSUE;
                            sd_begin_read <= 1'b1;
                            sd_addr       <= next_sd_addr;
                            tmo_cnt       <= '0;
                        end
                    end

                    S_ISSUE: begin
                        state    <= S_WAIT_ACK;
                        ack_wait <= 1'b0;
                    end

                    S_WAIT_ACK: begin
                        if (!sd_idle) begin
                            state <= S_RECEIVE;
                        end else if (ack_wait) begin
                            // command not taken after two cycles: pulse again
                            state         <= S_ISSUE;
                            sd_begin_read <= 1'b1;
                            sd_addr       <= next_sd_addr;
                            tmo_cnt       <= '0;
                            ack_wait      <= 1'b0;
                        end else begin
                            ack_wait <= 1'b1;
                        end
                    end

                    S_RECEIVE: begin
                        if (sd_byte_valid) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= sd_byte;
                            mem_addr  <= next_mem_addr;
                            byte_cnt  <= byte_cnt + 9'd1;
                            if (byte_cnt == 9'd511)
                                state <= S_SECT_END;
                        end
                    end

                    S_SECT_END: begin
                        sect_cnt <= sect_cnt + 16'd1;
                        if (sect_cnt + 16'd1 == num_sectors) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            // WAIT_RDY also absorbs the CRC trailer bytes
                            state <= S_WAIT_RDY;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_loader.sv
`timescale 1ns/1ps
module tb_sd_sector_loader;

    localparam int AW  = 16;
    localparam int TMO = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   start_sector = '0;
    logic [15:0]   sector_count = '0;
    logic [AW-1:0] dest_base = '0;
    logic          sd_idle = 1'b1;
    logic          sd_byte_valid = 1'b0;
    logic [7:0]    sd_byte = '0;
    // set by the SD stimulus for payload bytes; CRC/stray bytes leave it low
    logic          byte_counted = 1'b0;

    logic          busy_a, done_a, error_a, br_a, we_a;
    logic [31:0]   sa_a;
    logic [AW-1:0] ma_a;
    logic [7:0]    md_a;
    logic          busy_b, done_b, error_b, br_b, we_b;
    logic [31:0]   sa_b;
    logic [AW-1:0] ma_b;
    logic [7:0]    md_b;

    // block-addressed card
    sd_sector_loader #(.MEM_ADDR_W(AW), .SECTOR_SHIFT(0), .TIMEOUT_CYCLES(TMO)) dut_a (
        .clock(clock), .reset(reset), .start(start), .start_sector(start_sector),
        .sector_count(sector_count), .dest_base(dest_base), .busy(busy_a), .done(done_a),
        .error(error_a), .sd_idle(sd_idle), .sd_byte_valid(sd_byte_valid), .sd_byte(sd_byte),
        .sd_begin_read(br_a), .sd_addr(sa_a), .mem_we(we_a), .mem_addr(ma_a), .mem_wdata(md_a));

    // byte-addressed card, same stimulus
    sd_sector_loader #(.MEM_ADDR_W(AW), .SECTOR_SHIFT(9), .TIMEOUT_CYCLES(TMO)) dut_b (
        .clock(clock), .reset(reset), .start(start), .start_sector(start_sector),
        .sector_count(sector_count), .dest_base(dest_base), .busy(busy_b), .done(done_b),
        .error(error_b), .sd_idle(sd_idle), .sd_byte_valid(sd_byte_valid), .sd_byte(sd_byte),
        .sd_begin_read(br_b), .sd_addr(sa_b), .mem_we(we_b), .mem_addr(ma_b), .mem_wdata(md_b));

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc++;

    // ---------------- transaction-level model ----------------
    // A transfer is N*512 payload bytes; byte k goes to dest+k one cycle after
    // its strobe; done follows the last write; 64 cycles without a payload byte
    // while active ends in error.
    bit            m_active, m_busy, m_done, m_error, m_we;
    logic [AW-1:0] m_addr, m_dest;
    logic [7:0]    m_data;
    logic [31:0]   m_ss;
    int            m_cnt, m_total, m_since;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active <= 0; m_busy <= 0; m_done <= 0; m_error <= 0; m_we <= 0;
            m_addr <= '0; m_dest <= '0; m_data <= '0; m_ss <= '0;
            m_cnt <= 0; m_total <= 0; m_since <= 0;
        end else begin
            m_we   <= 0;
            m_done <= 0;
            if (m_active && m_we && m_cnt == m_total) begin
                m_done <= 1; m_busy <= 0; m_active <= 0;
            end else if (m_active) begin
                if (sd_byte_valid && byte_counted) begin
                    m_we    <= 1;
                    m_addr  <= AW'(32'(m_dest) + 32'(m_cnt));
                    m_data  <= sd_byte;
                    m_cnt   <= m_cnt + 1;
                    m_since <= 0;
                end else begin
                    m_since <= m_since + 1;
                    if (m_since + 1 >= TMO) begin
                        m_error <= 1; m_busy <= 0; m_active <= 0;
                    end
                end
            end else if (start) begin
                m_ss    <= start_sector;
                m_dest  <= dest_base;
                m_total <= int'(sector_count) * 512;
                m_cnt   <= 0;
                m_since <= 0;
                m_error <= 0;
                if (sector_count == 16'd0) m_done <= 1;
                else begin m_busy <= 1; m_active <= 1; end
            end
        end
    end

    // ---------------- per-cycle compare + monitors ----------------
    logic        last_idle = 1'b1;
    logic        pb_a = 1'b0, pb_b = 1'b0;
    logic [31:0] exp_sec;
    int          n_done = 0, n_wr = 0;
    logic [AW-1:0] last_wr = '0, first_wr = '0;
    bit          first_seen = 1'b0;
    logic [31:0] alog_a[$];
    logic [31:0] alog_b[$];

    always @(posedge clock) last_idle <= sd_idle;

    always @(negedge clock) begin
        if (!reset && run_chk) begin
            chk("busy_a", 32'(busy_a), 32'(m_busy));
            chk("busy_b", 32'(busy_b), 32'(m_busy));
            chk("done_a", 32'(done_a), 32'(m_done));
            chk("done_b", 32'(done_b), 32'(m_done));
            chk("error_a", 32'(error_a), 32'(m_error));
            chk("error_b", 32'(error_b), 32'(m_error));
            chk("mem_we_a", 32'(we_a), 32'(m_we));
            chk("mem_we_b", 32'(we_b), 32'(m_we));
            if (m_we) begin
                chk("mem_addr_a", 32'(ma_a), 32'(m_addr));
                chk("mem_addr_b", 32'(ma_b), 32'(m_addr));
                chk("mem_wdata_a", 32'(md_a), 32'(m_data));
                chk("mem_wdata_b", 32'(md_b), 32'(m_data));
            end
            exp_sec = m_ss + 32'(m_cnt / 512);
            if (br_a) begin
                chk("sd_addr_a", sa_a, exp_sec);
                chk("br_len_a", 32'(pb_a), 32'd0);
                chk("br_after_idle_a", 32'(last_idle), 32'd1);
                chk("br_while_busy_a", 32'(m_busy), 32'd1);
            end
            if (br_b) begin
                chk("sd_addr_b", sa_b, exp_sec << 9);
                chk("br_len_b", 32'(pb_b), 32'd0);
            end
            pb_a = br_a;
            pb_b = br_b;
            if (br_a) alog_a.push_back(sa_a);
            if (br_b) alog_b.push_back(sa_b);
            if (done_a) n_done++;
            if (we_a) begin
                n_wr++;
                last_wr = ma_a;
                if (!first_seen) begin first_wr = ma_a; first_seen = 1'b1; end
            end
        end
    end

    // ---------------- stimulus ----------------
    int w0, d0, last_strobe_cyc, err_cyc;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic mark();
        alog_a.delete();
        alog_b.delete();
        w0 = n_wr;
        d0 = n_done;
        first_seen = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [15:0] n, input logic [AW-1:0] d);
        start_sector = s; sector_count = n; dest_base = d; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_read(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (br_a) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_read actual=none required=sd_begin_read within 200 cycles cycle=%0d", cyc);
        end
    endtask

    // SD side of one sector: acknowledge the read (optionally ignoring the
    // first pulse), stream nbytes, then CRC trailer and idle if finish=1.
    task automatic serve_sector(input int gap, input int nbytes, input bit finish,
                                input bit retry, input int seed);
        bit ok;
        wait_read(ok);
        if (!ok) return;
        if (retry) begin
            @(negedge clock);
            wait_read(ok);
            if (!ok) return;
        end
        sd_idle = 1'b0;
        tick(2);
        for (int i = 0; i < nbytes; i++) begin
            sd_byte_valid = 1'b1;
            byte_counted  = 1'b1;
            sd_byte       = 8'(i + seed);
            @(negedge clock);
            last_strobe_cyc = cyc;
            sd_byte_valid = 1'b0;
            byte_counted  = 1'b0;
            tick(gap);
        end
        if (finish) begin
            sd_byte_valid = 1'b1;
            sd_byte = 8'hC5;
            @(negedge clock);
            sd_byte = 8'h3A;
            @(negedge clock);
            sd_byte_valid = 1'b0;
            sd_idle = 1'b1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(busy_a), 0);
        chk({tag, "_done"},  32'(done_a), 0);
        chk({tag, "_error"}, 32'(error_a), 0);
        chk({tag, "_br"},    32'(br_a), 0);
        chk({tag, "_we"},    32'(we_a), 0);
        chk({tag, "_sdaddr"}, sa_a, 0);
        chk({tag, "_maddr"}, 32'(ma_a), 0);
        chk({tag, "_wdata"}, 32'(md_a), 0);
        chk({tag, "_we_b"},  32'(we_b), 0);
        chk({tag, "_sdaddr_b"}, sa_b, 0);
    endtask

    logic [31:0] exp_byt[3];
    logic [31:0] exp_blk[3];

    initial begin
        exp_byt = '{32'h400, 32'h600, 32'h800};
        exp_blk = '{32'd2, 32'd3, 32'd4};

        tick(3);
        chk_zero("reset");
        reset = 1'b0;
        run_chk = 1'b1;
        tick(2);

        // single sector, block addressing, data = index mod 256
        mark();
        pulse_start(32'd5, 16'd1, 16'h8000);
        serve_sector(1, 512, 1'b1, 1'b0, 0);
        tick(4);
        chk("t1_reads", 32'(alog_a.size()), 1);
        if (alog_a.size() == 1) chk("t1_addr_blk", alog_a[0], 32'h5);
        if (alog_b.size() == 1) chk("t1_addr_byt", alog_b[0], 32'hA00);
        chk("t1_writes", 32'(n_wr - w0), 512);
        chk("t1_first", 32'(first_wr), 32'h8000);
        chk("t1_last", 32'(last_wr), 32'h81FF);
        chk("t1_done", 32'(n_done - d0), 1);
        chk("t1_error", 32'(error_a), 0);

        // three sectors
        mark();
        pulse_start(32'd2, 16'd3, 16'h1000);
        for (int s = 0; s < 3; s++) serve_sector(2, 512, 1'b1, 1'b0, s * 7);
        tick(4);
        chk("t2_reads", 32'(alog_b.size()), 3);
        if (alog_b.size() == 3 && alog_a.size() == 3)
            for (int s = 0; s < 3; s++) begin
                chk("t2_addr_byt", alog_b[s], exp_byt[s]);
                chk("t2_addr_blk", alog_a[s], exp_blk[s]);
            end
        chk("t2_writes", 32'(n_wr - w0), 1536);
        chk("t2_last", 32'(last_wr), 32'h15FF);
        chk("t2_done", 32'(n_done - d0), 1);

        // zero count
        mark();
        pulse_start(32'd7, 16'd0, 16'h3000);
        chk("t3_done_next", 32'(done_a), 1);
        chk("t3_busy", 32'(busy_a), 0);
        tick(3);
        chk("t3_reads", 32'(alog_a.size()), 0);
        chk("t3_done_cnt", 32'(n_done - d0), 1);

        // start while busy is ignored; first read pulse is not acknowledged
        mark();
        pulse_start(32'd20, 16'd1, 16'h4000);
        fork
            serve_sector(1, 512, 1'b1, 1'b1, 3);
            begin tick(60); pulse_start(32'd99, 16'd2, 16'h0000); end
        join
        tick(4);
        chk("t3b_reads", 32'(alog_a.size()), 2);
        foreach (alog_a[i]) chk("t3b_addr", alog_a[i], 32'd20);
        chk("t3b_writes", 32'(n_wr - w0), 512);
        chk("t3b_last", 32'(last_wr), 32'h41FF);
        chk("t3b_done", 32'(n_done - d0), 1);

        // timeout after byte 100
        mark();
        pulse_start(32'd40, 16'd1, 16'h5000);
        serve_sector(0, 101, 1'b0, 1'b0, 0);
        err_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            if (error_a) begin err_cyc = cyc; break; end
            @(negedge clock);
        end
        chk("t4_timeout_cycles", 32'(err_cyc - last_strobe_cyc), 64);
        chk("t4_busy", 32'(busy_a), 0);
        chk("t4_writes", 32'(n_wr - w0), 101);
        chk("t4_no_done", 32'(n_done - d0), 0);
        sd_idle = 1'b1;
        tick(2);
        mark();
        pulse_start(32'd41, 16'd1, 16'h6000);
        chk("t4_error_cleared", 32'(error_a), 0);
        serve_sector(1, 512, 1'b1, 1'b0, 9);
        tick(4);
        if (alog_a.size() > 0) chk("t4_reload_addr", alog_a[0], 32'd41);
        chk("t4_reload_last", 32'(last_wr), 32'h61FF);
        chk("t4_reload_done", 32'(n_done - d0), 1);

        // address wrap with back-to-back strobes
        mark();
        pulse_start(32'd0, 16'd1, 16'hFF00);
        serve_sector(0, 512, 1'b1, 1'b0, 0);
        tick(4);
        chk("t5_writes", 32'(n_wr - w0), 512);
        chk("t5_first", 32'(first_wr), 32'hFF00);
        chk("t5_last", 32'(last_wr), 32'h00FF);

        // reset after byte 200 of the second sector
        mark();
        pulse_start(32'd10, 16'd2, 16'h2000);
        serve_sector(1, 512, 1'b1, 1'b0, 0);
        serve_sector(0, 201, 1'b0, 1'b0, 0);
        #2 reset = 1'b1;
        #1 chk_zero("t6_async");
        w0 = n_wr;
        @(negedge clock);
        sd_byte_valid = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        sd_byte_valid = 1'b0;
        sd_idle = 1'b1;
        tick(2);
        chk("t6_no_writes", 32'(n_wr - w0), 0);
        chk("t6_busy", 32'(busy_a), 0);
        mark();
        pulse_start(32'd3, 16'd1, 16'h0100);
        serve_sector(1, 512, 1'b1, 1'b0, 5);
        tick(4);
        chk("t6_reads", 32'(alog_a.size()), 1);
        if (alog_a.size() == 1) chk("t6_addr", alog_a[0], 32'd3);
        chk("t6_last", 32'(last_wr), 32'h02FF);
        chk("t6_done", 32'(n_done - d0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
